// File: rtl/sccb_master_cfg.sv
// SCCB (camera control bus) master: register writes (burst) and single-byte reads.
module sccb_master_cfg #(
  parameter int         CLK_DIV    = 400,
  parameter logic [7:0] DEV_ID     = 8'h42,
  parameter int         ADDR_BYTES = 1,
  parameter int         CHECK_ACK  = 1,
  localparam int        ADDR_W     = 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [7:0]        wdata,
  output logic              wdata_req,
  output logic [7:0]        rdata,
  output logic              rdata_vld,
  output logic              done,
  output logic              ack_err,
  output logic              sclk,
  output logic              sio_out,
  output logic              sio_oe,
  input  logic              sio_in
);

  localparam int             CW    = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  DRIVE = CW'(CLK_DIV / 4 - 1);
  localparam logic [CW-1:0]  HALF  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]  SAMP  = CW'(3 * CLK_DIV / 4 - 1);

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, RESTART} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [3:0]        bit_idx;
  logic [8:0]        byte_cnt;
  logic [8:0]        last_idx;
  logic              frame;
  logic              rd_r;
  logic [7:0]        len_r;
  logic [ADDR_W-1:0] addr_sh;
  logic [7:0]        wbuf;
  logic [7:0]        cur_byte;
  logic              sclk_r;
  logic              sio_r;
  logic              accept;
  logic              period_end;
  logic              read_byte;
  logic              addr_byte;
  logic              last_byte;
  logic              tx_bit;

  assign accept     = cmd_valid && cmd_ready;
  assign period_end = (cnt == LAST);
  assign read_byte  = frame && (byte_cnt == 9'd1);
  assign addr_byte  = !frame && (byte_cnt != 9'd0) && (byte_cnt <= 9'(ADDR_BYTES));
  assign last_byte  = (byte_cnt == last_idx);

  // Frame layout: index of the final byte in the current START..STOP segment
  always_comb begin
    last_idx = 9'(ADDR_BYTES) + {1'b0, len_r};
    if (frame)
      last_idx = 9'd1;
    else if (rd_r)
      last_idx = 9'(ADDR_BYTES);
  end

  // Byte currently on the wire and the bit to drive next
  always_comb begin
    cur_byte = wbuf;
    if (byte_cnt == 9'd0)
      cur_byte = frame ? (DEV_ID | 8'h01) : DEV_ID;
    else if (addr_byte)
      cur_byte = addr_sh[ADDR_W-1 -: 8];
    tx_bit = 1'b1;
    if (bit_idx != 4'd8 && !read_byte)
      tx_bit = cur_byte[~bit_idx[2:0]];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state logic: every non-idle state lasts whole bit periods
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = START;
      START:   if (period_end) state_n = BITS;
      BITS:    if (period_end && bit_idx == 4'd8 && last_byte) state_n = STOP;
      STOP:    if (period_end) state_n = (!frame && rd_r) ? RESTART : IDLE;
      RESTART: if (period_end) state_n = START;
      default: state_n = IDLE;
    endcase
  end

  // Handshake, bus enable and completion strobes
  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    sclk      = sclk_r;
    sio_out   = sio_r;
    sio_oe    = (state != IDLE);
    if (state == BITS)
      sio_oe = (bit_idx == 4'd8) ? read_byte : !read_byte;
    wdata_req = (state == BITS) && (bit_idx == 4'd8) && (cnt == '0) && !rd_r &&
                (byte_cnt >= 9'(ADDR_BYTES)) && !last_byte;
    done      = (state == STOP) && period_end && (frame || !rd_r);
    rdata_vld = done && rd_r;
  end

  // Command capture, bit/byte sequencing, read shifter and ack monitor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      frame    <= 1'b0;
      rd_r     <= 1'b0;
      len_r    <= 8'd0;
      addr_sh  <= '0;
      wbuf     <= 8'd0;
      rdata    <= 8'd0;
      ack_err  <= 1'b0;
    end else begin
      if (state == IDLE || period_end)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (accept) begin
        rd_r     <= cmd_rd;
        addr_sh  <= cmd_addr;
        len_r    <= (cmd_len == 8'd0) ? 8'd1 : cmd_len;
        frame    <= 1'b0;
        byte_cnt <= '0;
        bit_idx  <= '0;
        ack_err  <= 1'b0;
      end
      if (wdata_req)
        wbuf <= wdata;
      if (state == BITS) begin
        if (cnt == SAMP) begin
          if (read_byte && bit_idx != 4'd8)
            rdata <= {rdata[6:0], sio_in};
          if (!read_byte && bit_idx == 4'd8 && CHECK_ACK != 0 && sio_in)
            ack_err <= 1'b1;
        end
        if (period_end) begin
          if (bit_idx == 4'd8) begin
            bit_idx  <= '0;
            byte_cnt <= byte_cnt + 9'd1;
            if (addr_byte)
              addr_sh <= addr_sh << 8;
          end else begin
            bit_idx <= bit_idx + 4'd1;
          end
        end
      end
      if (state == STOP && period_end && !frame && rd_r) begin
        frame    <= 1'b1;
        byte_cnt <= '0;
        bit_idx  <= '0;
      end
    end
  end

  // Registered SCL/SDA so the pins never glitch on counter decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_r <= 1'b1;
      sio_r  <= 1'b1;
    end else begin
      case (state)
        START: begin
          if (cnt == DRIVE) sio_r <= 1'b0;
          if (period_end) sclk_r <= 1'b0;
        end
        BITS: begin
          if (cnt == DRIVE) sio_r <= tx_bit;
          if (cnt == HALF) sclk_r <= 1'b1;
          if (period_end) begin
            sclk_r <= 1'b0;
            if (bit_idx == 4'd8 && last_byte) sio_r <= 1'b0;
          end
        end
        STOP: begin
          if (cnt == HALF) sclk_r <= 1'b1;
          if (cnt == SAMP) sio_r <= 1'b1;
        end
        default: begin
          sclk_r <= 1'b1;
          sio_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_master_cfg.sv
// Testbench for sccb_master_cfg: bus decoder + transaction-level reference model.
module tb_sccb_master_cfg;

  localparam int CLK_DIV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid0 = 1'b0, cmd_valid1 = 1'b0, cmd_rd = 1'b0;
  logic [15:0] cmd_addr = 16'd0;
  logic [7:0]  cmd_len = 8'd0, wdata = 8'd0;
  logic sio_in = 1'b1;

  logic ready0, wreq0, rvld0, done0, ack0, sclk0, out0, oe0;
  logic ready1, wreq1, rvld1, done1, ack1, sclk1, out1, oe1;
  logic [7:0] rdata0, rdata1;

  logic sel = 1'b0;
  logic m_ready, m_wreq, m_rvld, m_done, m_ack, m_sclk, m_out, m_oe;
  logic [7:0] m_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sccb_master_cfg #(.CLK_DIV(CLK_DIV), .DEV_ID(8'h42), .ADDR_BYTES(1), .CHECK_ACK(1)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(ready0), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr[7:0]), .cmd_len(cmd_len), .wdata(wdata), .wdata_req(wreq0),
    .rdata(rdata0), .rdata_vld(rvld0), .done(done0), .ack_err(ack0), .sclk(sclk0),
    .sio_out(out0), .sio_oe(oe0), .sio_in(sio_in));

  sccb_master_cfg #(.CLK_DIV(CLK_DIV), .DEV_ID(8'h42), .ADDR_BYTES(2), .CHECK_ACK(0)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(ready1), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata(wdata), .wdata_req(wreq1),
    .rdata(rdata1), .rdata_vld(rvld1), .done(done1), .ack_err(ack1), .sclk(sclk1),
    .sio_out(out1), .sio_oe(oe1), .sio_in(sio_in));

  assign m_ready = sel ? ready1 : ready0;
  assign m_wreq  = sel ? wreq1  : wreq0;
  assign m_rvld  = sel ? rvld1  : rvld0;
  assign m_done  = sel ? done1  : done0;
  assign m_ack   = sel ? ack1   : ack0;
  assign m_sclk  = sel ? sclk1  : sclk0;
  assign m_out   = sel ? out1   : out0;
  assign m_oe    = sel ? oe1    : oe0;
  assign m_rdata = sel ? rdata1 : rdata0;

  // Bus decoder and slave: S=-1, P=-2, bits 0/1 sampled on sclk rise
  int   bus_log[$];
  int   seg_bits = 0;
  int   k_bit;
  logic rw_bit = 1'b0;
  logic p_sclk = 1'b1, p_line = 1'b1, cur_line;
  logic cur_ack = 1'b0;
  logic [7:0] cur_rbyte = 8'd0;

  always @(negedge clk) begin
    if (m_ready) sio_in = 1'b1;
    cur_line = m_oe ? m_out : sio_in;
    if (p_sclk && m_sclk && p_line && !cur_line) begin
      bus_log.push_back(-1);
      seg_bits = 0;
      rw_bit = 1'b0;
    end else if (p_sclk && m_sclk && !p_line && cur_line) begin
      if (bus_log.size() > 0 && bus_log[$] >= 0) void'(bus_log.pop_back());
      bus_log.push_back(-2);
    end else if (!p_sclk && m_sclk) begin
      bus_log.push_back(int'(cur_line));
      if (seg_bits == 7) rw_bit = cur_line;
      seg_bits++;
    end else if (p_sclk && !m_sclk) begin
      k_bit = seg_bits;
      if (rw_bit && k_bit >= 9 && k_bit <= 16) sio_in = cur_rbyte[16-k_bit];
      else if (k_bit % 9 == 8) sio_in = cur_ack;
      else sio_in = 1'b1;
    end
    p_sclk = m_sclk;
    p_line = m_oe ? m_out : sio_in;
  end

  // Reference model: expected symbol stream of a whole command
  int exp_log[$];

  task automatic push_byte(input logic [7:0] b, input int ninth);
    for (int i = 7; i >= 0; i--) exp_log.push_back(int'(b[i]));
    exp_log.push_back(ninth);
  endtask

  task automatic build_expected(input bit s, input bit rd, input logic [15:0] addr, input int n,
                                input logic [3:0][7:0] d, input bit ack, input logic [7:0] rb);
    exp_log.delete();
    exp_log.push_back(-1);
    push_byte(8'h42, int'(ack));
    if (s) push_byte(addr[15:8], int'(ack));
    push_byte(addr[7:0], int'(ack));
    if (rd) begin
      exp_log.push_back(-2);
      exp_log.push_back(-1);
      push_byte(8'h43, int'(ack));
      push_byte(rb, 1);
    end else begin
      for (int i = 0; i < n; i++) push_byte(d[i], int'(ack));
    end
    exp_log.push_back(-2);
  endtask

  typedef struct {
    bit sel; bit rd; logic [15:0] addr; logic [7:0] len; logic [3:0][7:0] d;
    bit ack; logic [7:0] rb; int exp_cycles; int exp_wreq; int exp_ack_err;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit s, input bit rd, input logic [15:0] addr, input logic [7:0] len,
                         input logic [3:0][7:0] d, input bit ack, input logic [7:0] rb,
                         input int cyc, input int wreq, input int aerr);
    vec_t v;
    v.sel = s; v.rd = rd; v.addr = addr; v.len = len; v.d = d; v.ack = ack; v.rb = rb;
    v.exp_cycles = cyc; v.exp_wreq = wreq; v.exp_ack_err = aerr;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int cyc, done_cyc, widx, rvld, rv_at_done, ready_done, ready_before, ack_mid, ack_clr, diffs, n;
    n = (v.len == 8'd0) ? 1 : int'(v.len);
    build_expected(v.sel, v.rd, v.addr, n, v.d, v.ack, v.rb);
    @(negedge clk);
    sel = v.sel; cur_ack = v.ack; cur_rbyte = v.rb;
    bus_log.delete();
    cmd_rd = v.rd; cmd_addr = v.addr; cmd_len = v.len;
    cmd_valid0 = !v.sel; cmd_valid1 = v.sel;
    #1 ready_before = int'(m_ready);
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    cmd_rd = 1'($urandom); cmd_addr = 16'($urandom); cmd_len = 8'($urandom);
    cyc = 0; done_cyc = -1; widx = 0; rvld = 0; rv_at_done = 0; ready_done = -1; ack_mid = 0; ack_clr = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (m_wreq) begin
        wdata = (widx < 4) ? v.d[widx] : 8'h00;
        widx++;
      end
      if (cyc == 9 * CLK_DIV) ack_clr = int'(m_ack);
      if (cyc == 10 * CLK_DIV) ack_mid = int'(m_ack);
      if (m_rvld) begin
        rvld++;
        if (m_done) rv_at_done = 1;
      end
      if (m_done) begin
        done_cyc = cyc;
        ready_done = int'(m_ready);
        break;
      end
    end
    if (done_cyc < 0) $display("[TB] FAIL done_timeout: no done within %0d cycles", cyc);
    check_output("ready_idle", ready_before, 1);
    check_output("done_cycles", done_cyc, v.exp_cycles);
    check_output("wdata_req_count", widx, v.exp_wreq);
    check_output("rdata_vld_count", rvld, int'(v.rd));
    check_output("rdata_vld_with_done", rv_at_done, int'(v.rd));
    check_output("ready_in_done", ready_done, 0);
    diffs = (bus_log.size() == exp_log.size()) ? 0 : 1000;
    if (diffs == 0)
      foreach (exp_log[i]) if (bus_log[i] != exp_log[i]) diffs++;
    if (diffs != 0)
      $display("[TB] bus log: got %0d symbols, expected %0d", bus_log.size(), exp_log.size());
    check_output("bus_log", diffs, 0);
    if (v.rd) check_output("rdata", int'(m_rdata), int'(v.rb));
    check_output("ack_clear_on_accept", ack_clr, 0);
    if (v.ack) check_output("ack_after_id", ack_mid, v.exp_ack_err);
    @(negedge clk);
    check_output("ready_after_done", int'(m_ready), 1);
    check_output("ack_err_end", int'(m_ack), v.exp_ack_err);
  endtask

  initial begin
    logic [3:0][7:0] d;
    bit s, rd, ack;
    int n, ab, saw_done;
    $display("[TB] start");

    // Reset values while rst is held
    repeat (3) @(negedge clk);
    check_output("rst_cmd_ready", int'(ready0), 0);
    check_output("rst_sclk", int'(sclk0), 1);
    check_output("rst_sio_out", int'(out0), 1);
    check_output("rst_sio_oe", int'(oe0), 0);
    check_output("rst_done", int'(done0), 0);
    check_output("rst_ack_err", int'(ack0), 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_rst", int'(ready0), 1);

    // Directed table: expected cycle counts are bit periods * CLK_DIV
    add_vec(0, 0, 16'h0012, 8'd1, {8'h00, 8'h00, 8'h00, 8'h80}, 0, 8'h00, 29 * CLK_DIV, 1, 0);
    add_vec(0, 0, 16'h005C, 8'd3, {8'h00, 8'h33, 8'h22, 8'h11}, 0, 8'h00, 47 * CLK_DIV, 3, 0);
    add_vec(0, 1, 16'h000A, 8'd0, {8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'hA5, 41 * CLK_DIV, 0, 0);
    add_vec(1, 0, 16'h3008, 8'd1, {8'h00, 8'h00, 8'h00, 8'h5A}, 0, 8'h00, 38 * CLK_DIV, 1, 0);
    add_vec(0, 0, 16'h0012, 8'd2, {8'h00, 8'h00, 8'hFE, 8'h01}, 1, 8'h00, 38 * CLK_DIV, 2, 1);
    add_vec(0, 0, 16'h0033, 8'd0, {8'h00, 8'h00, 8'h00, 8'h7E}, 0, 8'h00, 29 * CLK_DIV, 1, 0);
    add_vec(1, 0, 16'h1234, 8'd1, {8'h00, 8'h00, 8'h00, 8'hC3}, 1, 8'h00, 38 * CLK_DIV, 1, 0);
    add_vec(1, 1, 16'h3008, 8'd5, {8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'h3C, 50 * CLK_DIV, 0, 0);
    add_vec(0, 1, 16'h0077, 8'd0, {8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h0F, 41 * CLK_DIV, 0, 1);

    // Random commands, expectations from frame arithmetic
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom); rd = 1'($urandom); ack = 1'($urandom);
      d = 32'($urandom);
      n = $urandom_range(0, 4);
      ab = s ? 2 : 1;
      add_vec(s, rd, 16'($urandom), 8'(n), d, ack, 8'($urandom),
              (rd ? (32 + 9 * ab) : (2 + 9 * (1 + ab + (n == 0 ? 1 : n)))) * CLK_DIV,
              rd ? 0 : (n == 0 ? 1 : n), (ack && !s) ? 1 : 0);
    end

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Reset during the sub-address byte aborts without done
    @(negedge clk);
    sel = 1'b0; cur_ack = 1'b0;
    cmd_rd = 1'b0; cmd_addr = 16'h0044; cmd_len = 8'd1; cmd_valid0 = 1'b1;
    @(posedge clk);
    #1 cmd_valid0 = 1'b0;
    repeat (12 * CLK_DIV) @(negedge clk);
    check_output("mid_sclk_active", int'(oe0), 1);
    rst = 1'b1;
    #1;
    check_output("abort_sclk", int'(sclk0), 1);
    check_output("abort_sio_out", int'(out0), 1);
    check_output("abort_sio_oe", int'(oe0), 0);
    check_output("abort_cmd_ready", int'(ready0), 0);
    check_output("abort_wdata_req", int'(wreq0), 0);
    check_output("abort_rdata", int'(rdata0), 0);
    check_output("abort_rdata_vld", int'(rvld0), 0);
    check_output("abort_ack_err", int'(ack0), 0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0) saw_done = 1;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done0) saw_done = 1;
    end
    check_output("abort_no_done", saw_done, 0);
    apply_stimulus(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
